// File: rtl/battle_turn_scheduler.sv
// Battle turn sequencer: owns monster/player HP, walks IDLE/MENU/ACT/DODGE/WIN/LOSE, gates the bullet engine.
// Optional macro TURN_ESCALATE_EN: bullet_level climbs per dodge round and shortens later dodges.
module battle_turn_scheduler #(
  parameter int MON_HP_INIT    = 100,
  parameter int PLAYER_HP_INIT = 100,
  parameter int ATK_DMG        = 10,
  parameter int HEAL_AMT       = 20,
  parameter int DODGE_TICKS    = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       key_valid,
  input  logic [7:0] key,
  input  logic       dmg_valid,
  input  logic [7:0] dmg_amt,
  input  logic       heal_valid,
  input  logic [7:0] heal_amt,
  output logic [2:0] phase,
  output logic       menu_sel,
  output logic       bullet_run,
  output logic [7:0] ticks_left,
  output logic [7:0] mon_hp,
  output logic [7:0] player_hp,
  output logic [2:0] bullet_level
);
  localparam logic [7:0] MonInit    = 8'(MON_HP_INIT);
  localparam logic [7:0] PlayerInit = 8'(PLAYER_HP_INIT);
  localparam logic [7:0] AtkDmg     = 8'(ATK_DMG);
  localparam logic [7:0] HealAmt    = 8'(HEAL_AMT);
  localparam logic [7:0] KeyStart   = 8'h73;
  localparam logic [7:0] KeyLeft    = 8'h61;
  localparam logic [7:0] KeyRight   = 8'h64;
  localparam logic [7:0] KeyEnter   = 8'h0D;
  localparam logic [7:0] KeyRestart = 8'h72;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MENU  = 3'd1,
    ACT   = 3'd2,
    DODGE = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5
  } phase_t;

  phase_t     state;
  logic [7:0] dodgeLen;
  logic [7:0] hpAfterDmg;
  logic [7:0] hpAfterHeal;
  logic [7:0] actHeal;
  logic [7:0] monAfterAtk;
  logic [8:0] healSum;
  logic [8:0] actSum;

  assign phase = state;

`ifdef TURN_ESCALATE_EN
  logic [9:0] shrink;
  assign shrink   = {4'b0, bullet_level, 3'b0};
  assign dodgeLen = (10'(DODGE_TICKS) >= shrink + 10'd16) ? 8'(10'(DODGE_TICKS) - shrink) : 8'd16;
`else
  assign dodgeLen = 8'(DODGE_TICKS);
`endif

  // Damage is applied before heal; the heal sees the post-damage HP.
  always_comb begin
    hpAfterDmg = player_hp;
    if (dmg_valid) hpAfterDmg = (dmg_amt >= player_hp) ? '0 : player_hp - dmg_amt;
    healSum     = {1'b0, hpAfterDmg} + {1'b0, heal_amt};
    hpAfterHeal = hpAfterDmg;
    if (heal_valid) hpAfterHeal = (healSum > {1'b0, PlayerInit}) ? PlayerInit : healSum[7:0];
    actSum      = {1'b0, player_hp} + {1'b0, HealAmt};
    actHeal     = (actSum > {1'b0, PlayerInit}) ? PlayerInit : actSum[7:0];
    monAfterAtk = (mon_hp <= AtkDmg) ? '0 : mon_hp - AtkDmg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      menu_sel     <= 1'b0;
      bullet_run   <= 1'b0;
      ticks_left   <= '0;
      mon_hp       <= MonInit;
      player_hp    <= PlayerInit;
      bullet_level <= '0;
    end else begin
      case (state)
        IDLE: if (key_valid && key == KeyStart) state <= MENU;
        MENU: begin
          if (key_valid) begin
            if (key == KeyLeft)       menu_sel <= 1'b0;
            else if (key == KeyRight) menu_sel <= 1'b1;
            else if (key == KeyEnter) state    <= ACT;
          end
        end
        ACT: begin
          if (!menu_sel) mon_hp    <= monAfterAtk;
          else           player_hp <= actHeal;
          if (!menu_sel && monAfterAtk == '0) begin
            state <= WIN;
          end else begin
            state      <= DODGE;
            ticks_left <= dodgeLen;
            bullet_run <= 1'b1;
          end
        end
        DODGE: begin
          // A lethal hit wins over a same-cycle timeout and swallows any heal.
          if (hpAfterDmg == '0) begin
            player_hp  <= '0;
            state      <= LOSE;
            bullet_run <= 1'b0;
            ticks_left <= '0;
          end else begin
            player_hp <= hpAfterHeal;
            if (tick) begin
              if (ticks_left <= 8'd1) begin
                ticks_left <= '0;
                bullet_run <= 1'b0;
                state      <= MENU;
`ifdef TURN_ESCALATE_EN
                if (bullet_level != 3'd7) bullet_level <= bullet_level + 3'd1;
`endif
              end else begin
                ticks_left <= ticks_left - 8'd1;
              end
            end
          end
        end
        WIN, LOSE: begin
          bullet_run <= 1'b0;
          if (key_valid && key == KeyRestart) begin
            state        <= IDLE;
            mon_hp       <= MonInit;
            player_hp    <= PlayerInit;
            menu_sel     <= 1'b0;
            bullet_level <= '0;
            ticks_left   <= '0;
          end
        end
        default: begin
          state      <= IDLE;
          bullet_run <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_battle_turn_scheduler.sv
// Testbench for battle_turn_scheduler: directed scenarios plus random traffic against an integer reference model.
`timescale 1ns/1ps
module tb_battle_turn_scheduler;
  localparam int MonInit = 95;  // 95 leaves 5 HP after nine fights, exercising attack saturation
  localparam int PInit   = 100;
  localparam int Atk     = 10;
  localparam int HealAmt = 20;
  localparam int Dodge   = 100;
  localparam logic [7:0] KS = 8'h73, KA = 8'h61, KD = 8'h64, KE = 8'h0D, KR = 8'h72;

  logic clk = 1'b0, reset_n = 1'b0, tick = 1'b0, key_valid = 1'b0, dmg_valid = 1'b0, heal_valid = 1'b0;
  logic [7:0] key = '0, dmg_amt = '0, heal_amt = '0;
  logic [2:0] phase, bullet_level;
  logic       menu_sel, bullet_run;
  logic [7:0] ticks_left, mon_hp, player_hp;

  int checkCnt = 0;
  int passCnt  = 0;
  int mPhase, mMon, mPlayer, mSel, mRun, mTicks, mLevel;

  battle_turn_scheduler #(
    .MON_HP_INIT(MonInit), .PLAYER_HP_INIT(PInit), .ATK_DMG(Atk),
    .HEAL_AMT(HealAmt), .DODGE_TICKS(Dodge)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .key_valid(key_valid), .key(key),
    .dmg_valid(dmg_valid), .dmg_amt(dmg_amt), .heal_valid(heal_valid), .heal_amt(heal_amt),
    .phase(phase), .menu_sel(menu_sel), .bullet_run(bullet_run), .ticks_left(ticks_left),
    .mon_hp(mon_hp), .player_hp(player_hp), .bullet_level(bullet_level)
  );

  always #5 clk = ~clk;

  function automatic int dodgeLength();
`ifdef TURN_ESCALATE_EN
    return (Dodge - 8 * mLevel < 16) ? 16 : Dodge - 8 * mLevel;
`else
    return Dodge;
`endif
  endfunction

  task automatic modelReset();
    mPhase = 0; mMon = MonInit; mPlayer = PInit; mSel = 0; mRun = 0; mTicks = 0; mLevel = 0;
  endtask

  // Drive one cycle of inputs, advance the model by the game rules, return #1 after the edge.
  task automatic drive(input bit kv, input logic [7:0] k, input bit dv, input int da,
                       input bit hv, input int ha, input bit tk);
    int p;
    key_valid = kv; key = k; dmg_valid = dv; dmg_amt = 8'(da);
    heal_valid = hv; heal_amt = 8'(ha); tick = tk;
    case (mPhase)
      0: if (kv && k == KS) mPhase = 1;
      1: if (kv) begin
           if (k == KA) mSel = 0;
           else if (k == KD) mSel = 1;
           else if (k == KE) mPhase = 2;
         end
      2: begin
           if (mSel == 0) mMon = (mMon > Atk) ? mMon - Atk : 0;
           else mPlayer = (mPlayer + HealAmt > PInit) ? PInit : mPlayer + HealAmt;
           if (mSel == 0 && mMon == 0) mPhase = 4;
           else begin mPhase = 3; mRun = 1; mTicks = dodgeLength(); end
         end
      3: begin
           p = dv ? ((mPlayer > da) ? mPlayer - da : 0) : mPlayer;
           if (p == 0) begin
             mPlayer = 0; mPhase = 5; mRun = 0; mTicks = 0;
           end else begin
             if (hv) p = (p + ha > PInit) ? PInit : p + ha;
             mPlayer = p;
             if (tk) begin
               mTicks--;
               if (mTicks == 0) begin
                 mRun = 0; mPhase = 1;
`ifdef TURN_ESCALATE_EN
                 if (mLevel < 7) mLevel++;
`endif
               end
             end
           end
         end
      default: if (kv && k == KR) begin
                 mPhase = 0; mMon = MonInit; mPlayer = PInit; mSel = 0; mLevel = 0; mTicks = 0;
               end
    endcase
    @(posedge clk); #1;
    key_valid = 1'b0; dmg_valid = 1'b0; heal_valid = 1'b0; tick = 1'b0;
  endtask

  task automatic idle();
    drive(0, 8'h00, 0, 0, 0, 0, 0);
  endtask

  task automatic pressKey(input logic [7:0] k);
    drive(1, k, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    logic [7:0] k;
    reset_n = 1'b0; modelReset();
    repeat (2) @(posedge clk); #1;
    checkCnt++; if (phase !== 3'd0) $display("FAIL reset_phase got %0d expected 0", phase); else passCnt++;
    checkCnt++; if (mon_hp !== 8'(MonInit)) $display("FAIL reset_mon_hp got %0d expected %0d", mon_hp, MonInit); else passCnt++;
    checkCnt++; if (player_hp !== 8'(PInit)) $display("FAIL reset_player_hp got %0d expected %0d", player_hp, PInit); else passCnt++;
    checkCnt++; if (bullet_run !== 1'b0) $display("FAIL reset_bullet_run got %0d expected 0", bullet_run); else passCnt++;
    checkCnt++; if (ticks_left !== 8'd0 || menu_sel !== 1'b0 || bullet_level !== 3'd0)
      $display("FAIL reset_misc got ticks=%0d sel=%0d lvl=%0d expected 0/0/0", ticks_left, menu_sel, bullet_level); else passCnt++;
    reset_n = 1'b1;
    repeat (5) begin
      k = 8'($urandom_range(0, 255));
      if (k == KS) k = KA;
      pressKey(k);
      checkCnt++; if (phase !== 3'd0) $display("FAIL idle_ignore_key key=%0h got %0d expected 0", k, phase); else passCnt++;
    end
    pressKey(KS);
    checkCnt++; if (phase !== 3'd1) $display("FAIL start_to_menu got %0d expected 1", phase); else passCnt++;
  endtask

  task automatic test_menu_nav();
    logic [7:0] k;
    int expSel;
    repeat (10) begin
      k = ($urandom_range(0, 1) == 0) ? KA : KD;
      expSel = (k == KD) ? 1 : 0;
      pressKey(k);
      checkCnt++; if (menu_sel !== 1'(expSel) || phase !== 3'd1)
        $display("FAIL menu_nav got sel=%0d phase=%0d expected sel=%0d phase=1", menu_sel, phase, expSel); else passCnt++;
    end
  endtask

  task automatic test_fight_dodge();
    pressKey(KA);
    pressKey(KE);
    checkCnt++; if (phase !== 3'd2 || bullet_run !== 1'b0)
      $display("FAIL enter_act got phase=%0d run=%0d expected 2/0", phase, bullet_run); else passCnt++;
    idle();
    checkCnt++; if (mon_hp !== 8'(MonInit - Atk)) $display("FAIL fight_mon_hp got %0d expected %0d", mon_hp, MonInit - Atk); else passCnt++;
    checkCnt++; if (phase !== 3'd3 || bullet_run !== 1'b1 || ticks_left !== 8'(Dodge))
      $display("FAIL dodge_entry got phase=%0d run=%0d ticks=%0d expected 3/1/%0d", phase, bullet_run, ticks_left, Dodge); else passCnt++;
    for (int i = 0; i < 400 && mPhase == 3; i++) begin
      drive(0, 8'h00, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
      checkCnt++; if (ticks_left !== 8'(mTicks)) $display("FAIL dodge_countdown got %0d expected %0d", ticks_left, mTicks); else passCnt++;
    end
    checkCnt++; if (phase !== 3'd1 || bullet_run !== 1'b0 || bullet_level !== 3'(mLevel))
      $display("FAIL dodge_timeout got phase=%0d run=%0d lvl=%0d expected 1/0/%0d", phase, bullet_run, bullet_level, mLevel); else passCnt++;
  endtask

  task automatic test_strobes_outside_dodge();
    repeat (3) drive(0, 8'h00, 1, 50, 1, 50, 1);
    checkCnt++; if (player_hp !== 8'(PInit) || mon_hp !== 8'(mMon) || phase !== 3'd1 || ticks_left !== 8'd0)
      $display("FAIL menu_strobes got hp=%0d mon=%0d phase=%0d ticks=%0d expected %0d/%0d/1/0",
               player_hp, mon_hp, phase, ticks_left, PInit, mMon); else passCnt++;
  endtask

  task automatic test_heal();
    pressKey(KD);
    pressKey(KE);
    idle();
    checkCnt++; if (player_hp !== 8'(PInit) || phase !== 3'd3)
      $display("FAIL heal_menu_clamp got hp=%0d phase=%0d expected %0d/3", player_hp, phase, PInit); else passCnt++;
    drive(0, 8'h00, 1, 5, 0, 0, 0);
    checkCnt++; if (player_hp !== 8'd95) $display("FAIL dodge_dmg got %0d expected 95", player_hp); else passCnt++;
    drive(0, 8'h00, 0, 0, 1, 30, 0);
    checkCnt++; if (player_hp !== 8'd100) $display("FAIL heal_ceiling got %0d expected 100", player_hp); else passCnt++;
    drive(0, 8'h00, 1, 50, 0, 0, 0);
    drive(0, 8'h00, 1, 10, 1, 30, 0);
    checkCnt++; if (player_hp !== 8'd70) $display("FAIL dmg_then_heal got %0d expected 70", player_hp); else passCnt++;
    for (int i = 0; i < 300 && mPhase == 3; i++) drive(0, 8'h00, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0, 0, 1);
    checkCnt++; if (phase !== 3'd1 || player_hp !== 8'(mPlayer))
      $display("FAIL heal_round_end got phase=%0d hp=%0d expected 1/%0d", phase, player_hp, mPlayer); else passCnt++;
  endtask

  task automatic test_lose_same_tick();
    pressKey(KE);
    idle();
    drive(0, 8'h00, 1, mPlayer - 15, 0, 0, 0);
    checkCnt++; if (player_hp !== 8'd15) $display("FAIL lose_setup_hp got %0d expected 15", player_hp); else passCnt++;
    for (int i = 0; i < 300 && mTicks > 1; i++) drive(0, 8'h00, 0, 0, 0, 0, 1);
    drive(0, 8'h00, 1, 20, 1, 30, 1);
    checkCnt++; if (phase !== 3'd5 || player_hp !== 8'd0 || bullet_run !== 1'b0)
      $display("FAIL lose_on_final_tick got phase=%0d hp=%0d run=%0d expected 5/0/0", phase, player_hp, bullet_run); else passCnt++;
    drive(1, KA, 1, 5, 1, 50, 1);
    checkCnt++; if (phase !== 3'd5 || player_hp !== 8'd0) $display("FAIL lose_frozen got phase=%0d hp=%0d expected 5/0", phase, player_hp); else passCnt++;
    pressKey(KR);
    checkCnt++; if (phase !== 3'd0 || player_hp !== 8'(PInit) || mon_hp !== 8'(MonInit) || menu_sel !== 1'b0)
      $display("FAIL lose_restart got phase=%0d hp=%0d mon=%0d sel=%0d expected 0/%0d/%0d/0",
               phase, player_hp, mon_hp, menu_sel, PInit, MonInit); else passCnt++;
  endtask

  task automatic test_win_escalate();
    pressKey(KS);
    for (int round = 0; round < 20; round++) begin
      pressKey(KE);
      checkCnt++; if (bullet_run !== 1'b0) $display("FAIL act_run_low got %0d expected 0", bullet_run); else passCnt++;
      idle();
      if (mPhase == 4) break;
      checkCnt++; if (phase !== 3'd3 || ticks_left !== 8'(mTicks) || bullet_level !== 3'(mLevel))
        $display("FAIL round_entry got phase=%0d ticks=%0d lvl=%0d expected 3/%0d/%0d", phase, ticks_left, bullet_level, mTicks, mLevel); else passCnt++;
`ifdef TURN_ESCALATE_EN
      if (round == 3) begin
        checkCnt++; if (ticks_left !== 8'd76 || bullet_level !== 3'd3)
          $display("FAIL escalate_len got ticks=%0d lvl=%0d expected 76/3", ticks_left, bullet_level); else passCnt++;
      end
`endif
      for (int i = 0; i < 300 && mPhase == 3; i++) drive(0, 8'h00, 0, 0, 0, 0, 1);
    end
    checkCnt++; if (phase !== 3'd4 || mon_hp !== 8'd0 || bullet_run !== 1'b0)
      $display("FAIL win got phase=%0d mon=%0d run=%0d expected 4/0/0", phase, mon_hp, bullet_run); else passCnt++;
`ifdef TURN_ESCALATE_EN
    checkCnt++; if (bullet_level !== 3'd7) $display("FAIL level_saturate got %0d expected 7", bullet_level); else passCnt++;
`else
    checkCnt++; if (bullet_level !== 3'd0) $display("FAIL level_tied got %0d expected 0", bullet_level); else passCnt++;
`endif
    pressKey(KR);
    checkCnt++; if (phase !== 3'd0 || mon_hp !== 8'(MonInit) || player_hp !== 8'(PInit) || bullet_level !== 3'd0)
      $display("FAIL win_restart got phase=%0d mon=%0d hp=%0d lvl=%0d expected 0/%0d/%0d/0",
               phase, mon_hp, player_hp, bullet_level, MonInit, PInit); else passCnt++;
  endtask

  task automatic test_async_reset();
    pressKey(KS);
    pressKey(KE);
    idle();
    checkCnt++; if (bullet_run !== 1'b1) $display("FAIL pre_reset_run got %0d expected 1", bullet_run); else passCnt++;
    #2 reset_n = 1'b0;
    #1;
    checkCnt++; if (bullet_run !== 1'b0 || phase !== 3'd0 || mon_hp !== 8'(MonInit))
      $display("FAIL async_reset got run=%0d phase=%0d mon=%0d expected 0/0/%0d", bullet_run, phase, mon_hp, MonInit); else passCnt++;
    modelReset();
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] keys [5];
    logic [7:0] k;
    int sel;
    keys[0] = KS; keys[1] = KA; keys[2] = KD; keys[3] = KE; keys[4] = KR;
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 5);
      k = (sel < 5) ? keys[sel] : 8'($urandom_range(0, 255));
      drive($urandom_range(0, 9) < 3, k, $urandom_range(0, 9) == 0, $urandom_range(0, 30),
            $urandom_range(0, 9) == 0, $urandom_range(0, 40), $urandom_range(0, 1) == 1);
      checkCnt++; if (phase !== 3'(mPhase)) $display("FAIL rnd_phase n=%0d got %0d expected %0d", n, phase, mPhase); else passCnt++;
      checkCnt++; if (menu_sel !== 1'(mSel)) $display("FAIL rnd_sel n=%0d got %0d expected %0d", n, menu_sel, mSel); else passCnt++;
      checkCnt++; if (bullet_run !== 1'(mRun)) $display("FAIL rnd_run n=%0d got %0d expected %0d", n, bullet_run, mRun); else passCnt++;
      checkCnt++; if (ticks_left !== 8'(mTicks)) $display("FAIL rnd_ticks n=%0d got %0d expected %0d", n, ticks_left, mTicks); else passCnt++;
      checkCnt++; if (mon_hp !== 8'(mMon)) $display("FAIL rnd_mon n=%0d got %0d expected %0d", n, mon_hp, mMon); else passCnt++;
      checkCnt++; if (player_hp !== 8'(mPlayer)) $display("FAIL rnd_player n=%0d got %0d expected %0d", n, player_hp, mPlayer); else passCnt++;
      checkCnt++; if (bullet_level !== 3'(mLevel)) $display("FAIL rnd_level n=%0d got %0d expected %0d", n, bullet_level, mLevel); else passCnt++;
    end
  endtask

  initial begin
    test_reset();
    test_menu_nav();
    test_fight_dodge();
    test_strobes_outside_dodge();
    test_heal();
    test_lose_same_tick();
    test_win_escalate();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
